// File: rtl/dabble_bcd_conv_pkg.sv
// Shared state encodings and add-3 constants for the shift-and-add-3 BCD converter.
`default_nettype none
package dabble_bcd_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADJ_THR = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

endpackage
`default_nettype wire

// File: rtl/dabble_bcd_conv_adjust.sv
// Single-digit add-3 correction applied before each left shift.
`default_nettype none
module bcd_digit_adjust
  import dabble_bcd_conv_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_THR) ? (d_i + BCD_ADJ_ADD) : d_i;

endmodule
`default_nettype wire

// File: rtl/dabble_bcd_conv.sv
// Sequential binary-to-BCD converter: one input bit per clock, result latched on completion.
`default_nettype none
module dabble_bcd_conv
  import dabble_bcd_conv_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 6,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
);

  state_e                state_q, state_d;
  logic [BIN_W-1:0]      bin_sh_q, bin_sh_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic                  ovf_flag_q, ovf_flag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   adj_w;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (work_q[4*i +: 4]),
      .d_o (adj_w[4*i +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    bin_sh_d   = bin_sh_q;
    work_d     = work_q;
    ovf_flag_d = ovf_flag_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_sh_d   = bin;
          work_d     = '0;
          ovf_flag_d = 1'b0;
          cnt_d      = CNT_W'(BIN_W);
          state_d    = ST_OP;
        end
      end
      ST_OP: begin
        // The bit pushed out of the top digit is lost; remember that it happened.
        ovf_flag_d = ovf_flag_q | adj_w[4*DIGITS-1];
        work_d     = {adj_w[4*DIGITS-2:0], bin_sh_q[BIN_W-1]};
        bin_sh_d   = {bin_sh_q[BIN_W-2:0], 1'b0};
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = work_q;
        ovf_d   = ovf_flag_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_sh_q   <= '0;
      work_q     <= '0;
      ovf_flag_q <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_sh_q   <= bin_sh_d;
      work_q     <= work_d;
      ovf_flag_q <= ovf_flag_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign bcd       = bcd_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dabble_bcd_conv.sv
// Random and directed checks of two converter instances (6 and 4 digits) against a decimal model.
`default_nettype none
module tb_dabble_bcd_conv;

  localparam int BIN_W = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        ready6, done6, ovf6, ready4, done4, ovf4;
  logic [23:0] bcd6;
  logic [15:0] bcd4;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  dabble_bcd_conv u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .ready(ready6), .done_tick(done6), .overflow(ovf6), .bcd(bcd6)
  );

  dabble_bcd_conv #(.BIN_W(14), .DIGITS(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .ready(ready4), .done_tick(done4), .overflow(ovf4), .bcd(bcd4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v, input int d);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: a conversion occupies BIN_W+1 cycles after its accepting edge,
  // the last of which is the done pulse; results are decimal digits of the captured value.
  int          m_left = 0;
  int          m_val = 0;
  logic [23:0] m_bcd6 = '0;
  logic [23:0] m_bcd4 = '0;
  logic        m_ovf6 = 1'b0;
  logic        m_ovf4 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_val  <= 0;
      m_bcd6 <= '0;
      m_bcd4 <= '0;
      m_ovf6 <= 1'b0;
      m_ovf4 <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= BIN_W + 1;
        m_val  <= int'(bin);
      end
    end else begin
      if (m_left == 1) begin
        m_bcd6 <= to_bcd(m_val, 6);
        m_bcd4 <= to_bcd(m_val, 4);
        m_ovf6 <= (m_val >= 1000000);
        m_ovf4 <= (m_val >= 10000);
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    chk("ready6", 32'(ready6), 32'(m_left == 0));
    chk("done6", 32'(done6), 32'(m_left == 1));
    chk("bcd6", 32'(bcd6), 32'(m_bcd6));
    chk("ovf6", 32'(ovf6), 32'(m_ovf6));
    chk("ready4", 32'(ready4), 32'(m_left == 0));
    chk("done4", 32'(done4), 32'(m_left == 1));
    chk("bcd4", 32'(bcd4), 32'(m_bcd4));
    chk("ovf4", 32'(ovf4), 32'(m_ovf4));
    if (ready6 && done6) chk("ready_and_done", 32'd1, 32'd0);
  end

  task automatic launch(input int v);
    int g;
    g = 0;
    @(posedge clk); #2;
    while (!ready6 && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    if (!ready6) chk("ready_timeout", 32'(ready6), 32'd1);
    start = 1'b1;
    bin   = 14'(v);
    @(posedge clk); #2;
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done6 && edges < 100);
    if (!done6) chk("done_timeout", 32'(done6), 32'd1);
  endtask

  task automatic run_lit(input int v, input logic [23:0] e6, input logic [15:0] e4,
                         input logic o6, input logic o4);
    int ed;
    launch(v);
    wait_done(ed);
    chk("latency", 32'(ed), 32'd14);
    @(posedge clk); #1;
    chk("lit_bcd6", 32'(bcd6), 32'(e6));
    chk("lit_ovf6", 32'(ovf6), 32'(o6));
    chk("lit_bcd4", 32'(bcd4), 32'(e4));
    chk("lit_ovf4", 32'(ovf4), 32'(o4));
  endtask

  initial begin
    int nd, ed, t1, t2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bcd6", 32'(bcd6), 32'd0);
    chk("rst_ready", 32'(ready6), 32'd1);
    rst_n = 1'b1;

    run_lit(0,     24'h000000, 16'h0000, 1'b0, 1'b0);
    run_lit(9999,  24'h009999, 16'h9999, 1'b0, 1'b0);
    run_lit(16383, 24'h016383, 16'h6383, 1'b0, 1'b1);
    run_lit(1000,  24'h001000, 16'h1000, 1'b0, 1'b0);

    // Second start mid-conversion is ignored; old result holds until the done pulse.
    launch(5678);
    repeat (3) @(posedge clk);
    #2;
    start = 1'b1;
    bin   = 14'd1234;
    @(posedge clk); #2;
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done6) nd++;
      if (nd == 0) chk("hold_bcd6", 32'(bcd6), 32'h001000);
    end
    chk("single_done", 32'(nd), 32'd1);
    chk("midop_bcd6", 32'(bcd6), 32'h005678);

    // Reset part-way through a conversion.
    launch(321);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    chk("midrst_bcd6", 32'(bcd6), 32'd0);
    chk("midrst_ready", 32'(ready6), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done6) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'd0);

    // Back-to-back with start held high.
    @(posedge clk); #2;
    start = 1'b1;
    bin   = 14'd42;
    wait_done(ed);
    t1  = cyc;
    bin = 14'd43;
    @(posedge clk); #1;
    chk("b2b_first", 32'(bcd6), 32'h000042);
    wait_done(ed);
    t2 = cyc;
    chk("b2b_period", 32'(t2 - t1), 32'd16);
    @(posedge clk); #1;
    chk("b2b_second", 32'(bcd6), 32'h000043);
    #1;
    start = 1'b0;

    // Randomized traffic, including occasional asynchronous resets.
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #2;
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: bin = 14'd0;
        1: bin = 14'd16383;
        2: bin = 14'd9999;
        3: bin = 14'd10000;
        default: bin = 14'($urandom);
      endcase
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
